// File: rtl/hamming_receiver.sv
// -----------------------------------------------------------------------------
// hamming_receiver
//
// Receives Hamming(11,7) codewords (even parity, parity bits at positions
// 1,2,4,8, data at 3,5,6,7,9,10,11), corrects single-bit errors, flags
// uncorrectable syndromes, presents the 7-bit data word in parallel and
// then serializes it MSB first.
//
// A frame starts on a rising edge of send. The codeword is latched on that
// edge, decoded one cycle later (data_valid pulse), and shifted out over the
// following seven cycles. A new edge before the last bit aborts the stream
// (overrun pulse); an edge exactly on the last bit chains frames back to back.
//
// Optional feature: define HAMMING_RX_STATS_EN to enable the saturating
// corrected / uncorrectable frame counters. Without it both counter ports
// are tied to zero.
//
// Ports:
//   clk               in   system clock, rising edge
//   reset             in   asynchronous reset, active low
//   code[10:0]        in   codeword, code[i-1] carries position i
//   send              in   frame strobe, rising edge starts a frame
//   data[6:0]         out  decoded, corrected data word (held)
//   data_valid        out  one-cycle pulse when data and flags update
//   serial_out        out  serialized data, data[6] first
//   serial_valid      out  high while serial_out carries a data bit
//   err_corrected     out  last frame had a corrected single-bit error
//   err_uncorrectable out  last frame had an uncorrectable syndrome
//   overrun           out  one-cycle pulse when a frame aborts serialization
//   corr_count        out  frames with err_corrected set (saturating)
//   uncorr_count      out  frames with err_uncorrectable set (saturating)
// -----------------------------------------------------------------------------
module hamming_receiver #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      code,
    input  logic             send,
    output logic [6:0]       data,
    output logic             data_valid,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             err_corrected,
    output logic             err_uncorrectable,
    output logic             overrun,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SHIFT  = 2'd2
    } state_t;

    state_t      state_reg, state_next;

    logic        send_d_reg;
    logic        send_edge;
    logic [10:0] code_reg;
    logic [6:0]  data_reg;
    logic        err_corrected_reg;
    logic        err_uncorrectable_reg;
    logic        data_valid_reg;
    logic        overrun_reg;
    logic [6:0]  shreg_reg;
    logic [2:0]  bit_cnt_reg;

    // FSM control strobes
    logic        latch_code;
    logic        load_decode;
    logic        shift_en;
    logic        overrun_next;

    // Decoder signals
    logic [3:0]  syndrome;
    logic [10:0] flip;
    logic [10:0] corrected;
    logic [6:0]  dec_data;
    logic        dec_corr;
    logic        dec_uncorr;

    // Positions covered by syndrome bit k: every position whose 1-based
    // index has bit k set (this includes the parity bit itself).
    function automatic logic [10:0] syn_mask(input int k);
        logic [10:0] m;
        m = '0;
        for (int j = 0; j < 11; j++) begin
            m[j] = ((j + 1) & (1 << k)) != 0;
        end
        return m;
    endfunction

    assign send_edge = send & ~send_d_reg;

    // -------------------------------------------------------------------------
    // Decoder (combinational on the latched codeword)
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_syn
            assign syndrome[gi] = ^(code_reg & syn_mask(gi));
        end
        // One-hot flip mask: only syndromes 1..11 name a real position, so
        // syndrome 0 and 12..15 leave the word untouched.
        for (gi = 0; gi < 11; gi++) begin : g_flip
            assign flip[gi] = (syndrome == 4'(gi + 1));
        end
    endgenerate

    assign corrected  = code_reg ^ flip;
    assign dec_data   = {corrected[10], corrected[9], corrected[8],
                         corrected[6], corrected[5], corrected[4],
                         corrected[2]};
    assign dec_corr   = |flip;
    assign dec_uncorr = syndrome[3] & syndrome[2];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        latch_code   = 1'b0;
        load_decode  = 1'b0;
        shift_en     = 1'b0;
        overrun_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (send_edge) begin
                    latch_code = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                load_decode = 1'b1;
                state_next  = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (send_edge) begin
                    // An edge on the last bit is a legal back-to-back frame;
                    // any earlier edge cuts the current stream short.
                    latch_code   = 1'b1;
                    overrun_next = (bit_cnt_reg != 3'd6);
                    state_next   = DECODE;
                end else if (bit_cnt_reg == 3'd6) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            send_d_reg            <= 1'b1;  // send held high through reset is not a frame
            code_reg              <= '0;
            data_reg              <= '0;
            err_corrected_reg     <= 1'b0;
            err_uncorrectable_reg <= 1'b0;
            data_valid_reg        <= 1'b0;
            overrun_reg           <= 1'b0;
            shreg_reg             <= '0;
            bit_cnt_reg           <= '0;
        end else begin
            send_d_reg     <= send;
            data_valid_reg <= load_decode;
            overrun_reg    <= overrun_next;
            if (latch_code) begin
                code_reg <= code;
            end
            if (load_decode) begin
                data_reg              <= dec_data;
                err_corrected_reg     <= dec_corr;
                err_uncorrectable_reg <= dec_uncorr;
                shreg_reg             <= dec_data;
                bit_cnt_reg           <= '0;
            end else if (shift_en) begin
                // The seventh shift empties the register, so serial_out
                // idles low after a completed stream.
                shreg_reg   <= {shreg_reg[5:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
        end
    end

    assign data              = data_reg;
    assign data_valid        = data_valid_reg;
    assign err_corrected     = err_corrected_reg;
    assign err_uncorrectable = err_uncorrectable_reg;
    assign overrun           = overrun_reg;
    assign serial_valid      = (state_reg == SHIFT);
    assign serial_out        = shreg_reg[6];

    // -------------------------------------------------------------------------
    // Statistics counters
    // -------------------------------------------------------------------------
`ifdef HAMMING_RX_STATS_EN
    logic [CNT_W-1:0] corr_count_reg;
    logic [CNT_W-1:0] uncorr_count_reg;

    // Counters advance on the same edge that loads the flags, so they stay
    // consistent with the data_valid pulse that follows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corr_count_reg   <= '0;
            uncorr_count_reg <= '0;
        end else if (load_decode) begin
            if (dec_corr && (corr_count_reg != {CNT_W{1'b1}})) begin
                corr_count_reg <= corr_count_reg + 1'b1;
            end
            if (dec_uncorr && (uncorr_count_reg != {CNT_W{1'b1}})) begin
                uncorr_count_reg <= uncorr_count_reg + 1'b1;
            end
        end
    end

    assign corr_count   = corr_count_reg;
    assign uncorr_count = uncorr_count_reg;
`else
    assign corr_count   = '0;
    assign uncorr_count = '0;
`endif

endmodule

// File: tb/tb_hamming_receiver.sv
// -----------------------------------------------------------------------------
// tb_hamming_receiver
//
// Directed and randomized frames against a reference model that works from
// the code's definition: the syndrome is the XOR of the indices of all set
// positions, and data bits sit at positions 3,5,6,7,9,10,11. Counter width
// is reduced so saturation is reached when the statistics macro is defined.
// -----------------------------------------------------------------------------
module tb_hamming_receiver;

    localparam int TB_CNT_W = 3;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef HAMMING_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [10:0]         code;
    logic                send;
    logic [6:0]          data;
    logic                data_valid;
    logic                serial_out;
    logic                serial_valid;
    logic                err_corrected;
    logic                err_uncorrectable;
    logic                overrun;
    logic [TB_CNT_W-1:0] corr_count;
    logic [TB_CNT_W-1:0] uncorr_count;

    always #5 clk = ~clk;

    hamming_receiver #(.CNT_W(TB_CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .code              (code),
        .send              (send),
        .data              (data),
        .data_valid        (data_valid),
        .serial_out        (serial_out),
        .serial_valid      (serial_valid),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .overrun           (overrun),
        .corr_count        (corr_count),
        .uncorr_count      (uncorr_count)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: counts pulses/cycles and records the serial stream.
    int dv_count = 0;
    int sv_count = 0;
    int ov_count = 0;
    bit ser_q[$];

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (data_valid === 1'b1) dv_count++;
            if (overrun === 1'b1) ov_count++;
            if (serial_valid === 1'b1) begin
                sv_count++;
                ser_q.push_back(serial_out);
            end
        end
    end

    // Reference model state
    int         data_pos[7] = '{3, 5, 6, 7, 9, 10, 11};
    logic [6:0] exp_data;
    logic       exp_corr;
    logic       exp_unc;
    int         corr_m = 0;
    int         unc_m  = 0;

    function automatic logic [3:0] syn_of(input logic [10:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int p = 1; p <= 11; p++) begin
            if (cw[p-1]) s = s ^ 4'(p);
        end
        return s;
    endfunction

    function automatic logic [10:0] encode(input logic [6:0] d);
        logic [10:0] cw;
        logic [3:0]  s;
        cw = '0;
        for (int i = 0; i < 7; i++) cw[data_pos[i]-1] = d[i];
        s = syn_of(cw);
        for (int k = 0; k < 4; k++) cw[(1 << k) - 1] = s[k];
        return cw;
    endfunction

    task automatic model_frame(input logic [10:0] cw);
        logic [3:0]  s;
        logic [10:0] w;
        s = syn_of(cw);
        w = cw;
        if (s >= 1 && s <= 11) w[s-1] = ~w[s-1];
        for (int i = 0; i < 7; i++) exp_data[i] = w[data_pos[i]-1];
        exp_corr = (s >= 1 && s <= 11);
        exp_unc  = (s >= 12);
        if (STATS) begin
            if (exp_corr && corr_m < CNT_MAX) corr_m++;
            if (exp_unc && unc_m < CNT_MAX) unc_m++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_q(input int from);
        logic [31:0] v;
        v = '0;
        for (int i = from; i < ser_q.size(); i++) v = {v[30:0], ser_q[i]};
        return v;
    endfunction

    task automatic wait_dv();
        int lat;
        bit found;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 6) begin
            tick();
            lat++;
            if (data_valid === 1'b1) found = 1'b1;
        end
        check("latency", lat, 1);
    endtask

    task automatic check_counts();
        check("corr_count", corr_count, corr_m);
        check("uncorr_count", uncorr_count, unc_m);
    endtask

    // Full isolated frame: edge, decode check, 7-bit stream check, counters.
    task automatic do_frame(input logic [10:0] cw);
        int q0;
        q0 = ser_q.size();
        model_frame(cw);
        code = cw;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_dv();
        check("data", data, exp_data);
        check("err_corrected", err_corrected, exp_corr);
        check("err_uncorrectable", err_uncorrectable, exp_unc);
        repeat (8) tick();
        check("serial_bits", {ser_q.size() - q0, pack_q(q0)[15:0]}, {7, 9'd0, exp_data});
        check("serial_idle", serial_valid, 1'b0);
        check_counts();
    endtask

    function automatic logic [10:0] random_cw();
        logic [10:0] cw;
        int          a, b;
        cw = encode(7'($urandom_range(0, 127)));
        case ($urandom_range(0, 3))
            1: begin
                a = $urandom_range(1, 11);
                cw[a-1] = ~cw[a-1];
            end
            2: begin
                a = $urandom_range(1, 11);
                b = $urandom_range(1, 10);
                if (b >= a) b++;
                cw[a-1] = ~cw[a-1];
                cw[b-1] = ~cw[b-1];
            end
            3: cw = 11'($urandom());
            default: ;
        endcase
        return cw;
    endfunction

    initial begin
        int          dv0, sv0, ov0, q0;
        logic [6:0]  d1;
        logic [31:0] exp_bits;
        logic [10:0] cw;

        reset = 1'b0;
        send  = 1'b0;
        code  = '0;
        repeat (3) tick();

        // Reset state
        check("rst_data", data, 7'h00);
        check("rst_flags", {data_valid, serial_valid, serial_out, err_corrected, err_uncorrectable, overrun}, 6'b0);
        check("rst_counts", {corr_count, uncorr_count}, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Clean frame
        do_frame(11'h51C);
        check("clean_lit", {data, err_corrected, err_uncorrectable}, {7'h53, 2'b00});
        // Single error at position 6
        do_frame(11'h53C);
        check("single_lit", {data, err_corrected, err_uncorrectable}, {7'h53, 2'b10});
        // Double error at positions 5 and 9: syndrome 12
        do_frame(11'h40C);
        check("double_lit", {data, err_corrected, err_uncorrectable}, {7'h41, 2'b01});

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            do_frame(random_cw());
            $display("frame %0d: code=%03h data=%02h corr=%0d unc=%0d", n, code, data, err_corrected, err_uncorrectable);
        end

        // Back-to-back frames every 8 cycles
        dv0 = dv_count; sv0 = sv_count; ov0 = ov_count; q0 = ser_q.size();
        exp_bits = '0;
        for (int f = 0; f < 4; f++) begin
            cw = random_cw();
            model_frame(cw);
            exp_bits = {exp_bits[24:0], exp_data};
            code = cw;
            send = 1'b1;
            tick();
            send = 1'b0;
            repeat (7) tick();
        end
        repeat (10) tick();
        check("b2b_data_valid", dv_count - dv0, 4);
        check("b2b_serial_cycles", sv_count - sv0, 28);
        check("b2b_overrun", ov_count - ov0, 0);
        check("b2b_serial_bits", pack_q(q0), exp_bits);
        check("b2b_last_data", data, exp_data);
        check_counts();

        // Early frame: second edge four cycles after the first data_valid
        dv0 = dv_count; sv0 = sv_count; ov0 = ov_count; q0 = ser_q.size();
        cw = random_cw();
        model_frame(cw);
        d1 = exp_data;
        code = cw;
        send = 1'b1;
        tick();
        send = 1'b0;
        tick();
        check("early_first_dv", data_valid, 1'b1);
        repeat (3) tick();
        cw = random_cw();
        model_frame(cw);
        code = cw;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (12) tick();
        check("early_overrun", ov_count - ov0, 1);
        check("early_data_valid", dv_count - dv0, 2);
        check("early_serial_cycles", sv_count - sv0, 11);
        check("early_serial_bits", pack_q(q0), {21'd0, d1[6:3], exp_data});
        check("early_data", data, exp_data);
        check_counts();

        // Reset mid-SHIFT with send held high through release
        cw = random_cw();
        code = cw;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (3) tick();
        send = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        corr_m = 0;
        unc_m  = 0;
        check("midrst_data", data, 7'h00);
        check("midrst_flags", {data_valid, serial_valid, serial_out, err_corrected, err_uncorrectable, overrun}, 6'b0);
        check_counts();
        tick();
        tick();
        reset = 1'b1;
        dv0 = dv_count; sv0 = sv_count; ov0 = ov_count;
        repeat (6) tick();
        check("rst_release_no_frame", {dv_count - dv0, sv_count - sv0, ov_count - ov0}, 0);
        check("rst_release_data", data, 7'h00);
        send = 1'b0;
        tick();
        do_frame(encode(7'h2A));
        check("post_reset_data", data, 7'h2A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hamming_receiver.md
HAMMING_RECEIVER -- requirements
Module: hamming_receiver

Interface
REQ-001 Parameter CNT_W, default 16: width of each statistics counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 code  input  11  Hamming(11,7) codeword; code[i-1] carries position i (1..11).
REQ-005 send  input  1  frame strobe, synchronous to clk; a 0->1 transition marks a new codeword on code.
REQ-006 data  output  7  decoded, corrected data word; held until the next decode.
REQ-007 data_valid  output  1  one-cycle pulse when data and the error flags update.
REQ-008 serial_out  output  1  decoded data serialized, MSB (data[6]) first.
REQ-009 serial_valid  output  1  high while serial_out carries a data bit.
REQ-010 err_corrected  output  1  last frame had a single-bit error, now corrected; held with data.
REQ-011 err_uncorrectable  output  1  last frame had an uncorrectable syndrome; held with data.
REQ-012 overrun  output  1  one-cycle pulse when a new frame aborts an unfinished serialization.
REQ-013 corr_count  output  CNT_W  count of frames with err_corrected set.
REQ-014 uncorr_count  output  CNT_W  count of frames with err_uncorrectable set.

Function
REQ-015 Even parity; parity bits at positions 1,2,4,8; data[0..6] at positions 3,5,6,7,9,10,11.
REQ-016 Syndrome s[3:0]: s[k] = XOR of all positions whose index has bit k set, including the parity bit itself.
REQ-017 s=0: data = extracted bits, both error flags 0.
REQ-018 s in 1..11: flip position s before extraction, err_corrected=1, err_uncorrectable=0.
REQ-019 s in 12..15: data = uncorrected extracted bits, err_uncorrectable=1, err_corrected=0.
REQ-020 Edge detect: registered send_d; edge = send & ~send_d, evaluated every cycle.
REQ-021 FSM states IDLE, DECODE, SHIFT.
REQ-022 IDLE: on edge at posedge T, latch code into code_reg and go to DECODE.
REQ-023 DECODE (one cycle): at posedge T+1, register data and flags, pulse data_valid, load 7-bit shift register, clear bit counter, go to SHIFT.
REQ-024 SHIFT: serial_valid=1, serial_out=shreg[6]; shift left each cycle for 7 cycles.
REQ-025 SHIFT exit: after the 7th bit (first bit after T+1, last after T+7), return to IDLE at posedge T+8.
REQ-026 Edge in SHIFT with bit counter <6: latch code, pulse overrun, abort the shift, go to DECODE.
REQ-027 Edge in SHIFT with bit counter =6: latch code, go to DECODE, no overrun (back-to-back 8-cycle frames).
REQ-028 An edge cannot occur in DECODE, because send needs a low cycle between edges; no handling is required.
REQ-029 Latency: send edge sampled at posedge T -> data_valid high in the cycle after posedge T+1.

Reset
REQ-030 On reset low: state IDLE; data, code_reg, shreg and counters 0; all 1-bit outputs 0.
REQ-031 send_d resets to 1, so a send held high through reset release is not a frame.
REQ-032 Reset mid-SHIFT or mid-DECODE discards the frame immediately, with no data_valid or overrun pulse.

Configuration
REQ-033 Macro HAMMING_RX_STATS_EN defined: corr_count and uncorr_count each increment by 1 on a data_valid with the matching flag, saturating at all-ones.
REQ-034 Macro HAMMING_RX_STATS_EN absent: counter logic omitted; corr_count and uncorr_count driven constant 0; ports are retained.

Verification
REQ-035 Clean frame: code=11'h51C, send 0->1 -> data=7'h53 one cycle after posedge T+1, flags 0; serial bits 1,0,1,0,0,1,1 over 7 cycles.
REQ-036 Single error: code=11'h53C (position 6 flipped) -> data=7'h53, err_corrected=1, corr_count +1 (macro on).
REQ-037 Double error: code=11'h40C (positions 5,9 flipped) -> syndrome 12, data=7'h41, err_uncorrectable=1, uncorr_count +1 (macro on).
REQ-038 Back-to-back: send pulsed every 8 cycles for 4 frames -> 4 data_valid pulses, 28 serial_valid cycles, overrun never set.
REQ-039 Early frame: second send edge 4 cycles after the first data_valid -> overrun pulses once, serial stream restarts with the new data MSB.
REQ-040 Reset: reset low mid-SHIFT, send held high through release -> all outputs 0, no frame decoded until send returns 0 then 1.
